piso_tx: RTL and testbench
==========================

Name: piso_tx

Overview:
Parallel-in serial-out transmitter that sits directly upstream of the team's serial-to-parallel receiver and drives its serial_in.
- Accepts one WIDTH-bit word per valid/ready handshake.
- Shifts the word out MSB-first, one bit per clk. Because the receiver shifts in at the LSB, the word reassembles in its original order.
- Flags active bits with frame, reports occupancy with busy, and pulses done after each word.

Parameters:
WIDTH, 8, data word width in bits; legal range 2..32.

Ports:
clk  input  1  single clock; all state updates on posedge clk
rst  input  1  synchronous reset, active-high; sampled only on posedge clk
par_in  input  WIDTH  parallel word to transmit; sampled on accept
in_valid  input  1  upstream offers par_in
in_ready  output  1  block can accept a word this cycle
serial_out  output  1  registered serial bit; MSB first
frame  output  1  high while serial_out carries a valid bit
busy  output  1  high while in SHIFT (or PARITY) state
done  output  1  one-cycle pulse, registered, in the cycle after the last bit of a word

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, shift_reg=0, cnt=0, serial_out=0, frame=0, busy=0, done=0. in_ready=1 in the cycle after reset.
- Reset applied mid-frame aborts the word immediately. No done pulse is produced, and the word is not resumed.
- Accept: the handshake completes at the posedge where in_valid && in_ready.
- in_ready is combinational: high in IDLE; high in SHIFT only when cnt==0 (last bit), or in PARITY when that state exists. It is low otherwise.
- States:
  - IDLE: frame=0, busy=0. On accept: shift_reg<=par_in, serial_out<=par_in[WIDTH-1], cnt<=WIDTH-1, frame<=1, go to SHIFT.
  - SHIFT: each posedge with cnt>0: shift_reg<<1, serial_out<=next bit, cnt<=cnt-1.
    - At cnt==0 with accept: load the new word exactly as from IDLE (back-to-back, zero gap, frame stays high), and pulse done.
    - At cnt==0 without accept: go to IDLE, frame<=0, serial_out<=0, done<=1.
- Latency: the first bit appears in the cycle after the accept edge. A word occupies exactly WIDTH consecutive frame cycles. done is high in cycle WIDTH+1 counted from the first bit.
- par_in and in_valid are ignored whenever in_ready=0. Upstream must hold the word until acceptance.
- cnt width is clog2(WIDTH). It never wraps below 0.

Optional Feature:
Macro PISO_PARITY_EN.
- Defined: adds a PARITY state after SHIFT.
  - At cnt==0 the FSM moves to PARITY and serial_out<=^word, i.e. the even parity of the word latched at accept (held in a parity register).
  - frame stays high; each frame is WIDTH+1 cycles.
  - in_ready is high in PARITY instead of at SHIFT cnt==0. Back-to-back accept and done follow the same rules, applied at PARITY exit.
- Undefined: no PARITY state and no parity register; behaviour is exactly as above.

Decomposition:
- Shared package piso_pkg holds:
  - state typedef (IDLE, SHIFT, PARITY);
  - default WIDTH constant;
  - counter-width localparam derived from clog2(WIDTH).
- No sub-module. The counter, shifter and FSM stay in one module.

Test Plan:
- Single word: after reset, in_valid=1 with par_in=8'hA5 for one accept -> serial_out=1,0,1,0,0,1,0,1 over 8 cycles; frame high for exactly 8 cycles; done high in the 9th cycle; in_ready=1 afterwards.
- Back-to-back: 8'hFF then 8'h00 with in_valid held -> 16 contiguous frame cycles (eight 1s then eight 0s); second accept at cnt==0; one done pulse per word.
- Stall: in_valid held high with 8'h3C while mid-word -> in_ready stays 0 until cnt==0; 8'h3C is accepted only then; no bits are dropped or duplicated.
- Reset mid-frame: assert rst after 3 bits of 8'hF0 -> next cycle serial_out=0, frame=0, busy=0, in_ready=1, no done; the next word 8'h81 transmits correctly.
- Loopback: connect to the receiver with a common clk and rst, send 8'h5A -> receiver par_out=8'h5A one cycle after the 8th bit is sampled.
- PISO_PARITY_EN: send 8'h07 -> 8 data bits then parity bit 1; frame high for 9 cycles. Send 8'h03 -> parity bit 0.

Source files
------------

// File: rtl/piso_pkg.sv
// piso_pkg: shared types and constants for the piso_tx serializer.
// Holds the FSM state encoding, the default word width and the
// counter-width helper used to size the bit counter.
package piso_pkg;

  // Default data word width in bits (legal range 2..32).
  localparam int PISO_DEFAULT_WIDTH = 8;

  // Bit counter width for a given word width: the counter holds WIDTH-1 down to 0.
  function automatic int piso_cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  // Counter width for the default word width.
  localparam int PISO_CNT_W = piso_cnt_w(PISO_DEFAULT_WIDTH);

  // Transmitter FSM states. PARITY is only entered when the parity bit is built in.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } piso_state_t;

endpackage

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter, MSB first, one bit per clk.
// Optional build macro PISO_PARITY_EN appends an even-parity bit after
// each word (frame becomes WIDTH+1 cycles long).
//
// Handshake: a word transfers on the posedge where in_valid && in_ready.
// in_ready never depends on in_valid; upstream holds par_in stable while
// in_valid is high and in_ready is low. par_in is ignored when in_ready=0.
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] par_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             serial_out,
  output logic             frame,
  output logic             busy,
  output logic             done
);

  localparam int CW = piso_cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  piso_state_t      state, state_nxt;
  logic [WIDTH-1:0] shift_reg, shift_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             ser_nxt;
  logic             frame_nxt;
  logic             done_nxt;
  logic             accept;
  logic             load;
  logic             finish;
`ifdef PISO_PARITY_EN
  logic             par_reg, par_nxt;
`endif

  assign accept = in_valid && in_ready;
  assign busy   = (state != IDLE);

  // Ready is a pure function of state/count so it never waits on in_valid.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      IDLE:   in_ready = 1'b1;
`ifdef PISO_PARITY_EN
      SHIFT:  in_ready = 1'b0;
      PARITY: in_ready = 1'b1;
`else
      SHIFT:  in_ready = (cnt == '0);
      PARITY: in_ready = 1'b0;
`endif
      default: in_ready = 1'b0;
    endcase
  end

  // Next-state logic: shifting, end-of-word handling and word loading.
  always_comb begin
    state_nxt = state;
    shift_nxt = shift_reg;
    cnt_nxt   = cnt;
    ser_nxt   = serial_out;
    frame_nxt = frame;
    done_nxt  = 1'b0;
    load      = 1'b0;
    finish    = 1'b0;
`ifdef PISO_PARITY_EN
    par_nxt   = par_reg;
`endif

    case (state)
      IDLE: begin
        load = accept;
      end
      SHIFT: begin
        if (cnt != '0) begin
          shift_nxt = shift_reg << 1;
          ser_nxt   = shift_reg[WIDTH-2];
          cnt_nxt   = cnt - 1'b1;
        end else begin
`ifdef PISO_PARITY_EN
          state_nxt = PARITY;
          ser_nxt   = par_reg;
`else
          finish    = 1'b1;
`endif
        end
      end
      PARITY: begin
`ifdef PISO_PARITY_EN
        finish    = 1'b1;
`else
        state_nxt = IDLE;
`endif
      end
      default: begin
        state_nxt = IDLE;
        frame_nxt = 1'b0;
        ser_nxt   = 1'b0;
      end
    endcase

    // Last bit of the frame is on the line: either chain the next word
    // with no gap or fall back to IDLE with the line driven low.
    if (finish) begin
      done_nxt = 1'b1;
      if (accept) begin
        load = 1'b1;
      end else begin
        state_nxt = IDLE;
        frame_nxt = 1'b0;
        ser_nxt   = 1'b0;
      end
    end

    // Loading a word puts its MSB on the line in the very next cycle.
    if (load) begin
      state_nxt = SHIFT;
      shift_nxt = par_in;
      ser_nxt   = par_in[WIDTH-1];
      cnt_nxt   = CNT_LAST;
      frame_nxt = 1'b1;
`ifdef PISO_PARITY_EN
      par_nxt   = ^par_in;
`endif
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shift_reg  <= '0;
      cnt        <= '0;
      serial_out <= 1'b0;
      frame      <= 1'b0;
      done       <= 1'b0;
`ifdef PISO_PARITY_EN
      par_reg    <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      shift_reg  <= shift_nxt;
      cnt        <= cnt_nxt;
      serial_out <= ser_nxt;
      frame      <= frame_nxt;
      done       <= done_nxt;
`ifdef PISO_PARITY_EN
      par_reg    <= par_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed self-checking bench for piso_tx (WIDTH=8).
// Outputs are sampled on the falling edge; inputs change away from posedge.
module tb_piso_tx;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] par_in;
  logic         in_valid;
  logic         in_ready;
  logic         serial_out;
  logic         frame;
  logic         busy;
  logic         done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] rx_word;

  piso_tx #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .par_in     (par_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .serial_out (serial_out),
    .frame      (frame),
    .busy       (busy),
    .done       (done)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Offer one word at a falling edge; it is accepted at the next posedge.
  task automatic offer(input logic [W-1:0] w);
    par_in   = w;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Check nbits serial cycles of word w, reassembling them the way the
  // downstream receiver does (shift in at LSB while frame is high).
  task automatic check_word(input logic [W-1:0] w, input int nbits,
                            input logic first_done, output logic [W-1:0] rx);
    logic exp_rdy;
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
`ifdef PISO_PARITY_EN
      exp_rdy = 1'b0;
`else
      exp_rdy = (i == W - 1);
`endif
      check("bit",   32'(serial_out), 32'(w[W-1-i]));
      check("frame", 32'(frame), 32'd1);
      check("busy",  32'(busy), 32'd1);
      check("ready", 32'(in_ready), 32'(exp_rdy));
      check("done",  32'(done), (i == 0) ? 32'(first_done) : 32'd0);
      if (frame) rx = {rx[W-2:0], serial_out};
    end
`ifdef PISO_PARITY_EN
    if (nbits == W) begin
      @(negedge clk);
      check("par_bit",   32'(serial_out), 32'(^w));
      check("par_frame", 32'(frame), 32'd1);
      check("par_busy",  32'(busy), 32'd1);
      check("par_ready", 32'(in_ready), 32'd1);
      check("par_done",  32'(done), 32'd0);
    end
`endif
  endtask

  // The cycle after a word ends with nothing queued.
  task automatic check_idle_done();
    @(negedge clk);
    check("end_done",  32'(done), 32'd1);
    check("end_frame", 32'(frame), 32'd0);
    check("end_busy",  32'(busy), 32'd0);
    check("end_ser",   32'(serial_out), 32'd0);
    check("end_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    par_in   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_ser",   32'(serial_out), 32'd0);
    check("rst_frame", 32'(frame), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);

    // Single word A5, also reassembled as the receiver would.
    offer(8'hA5);
    check_word(8'hA5, W, 1'b0, rx_word);
    check("rx_a5", 32'(rx_word), 32'h0000_00A5);
    check_idle_done();
    @(negedge clk);
    check("done_once", 32'(done), 32'd0);

    // Back-to-back FF then 00 with in_valid held across the boundary.
    par_in   = 8'hFF;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    par_in = 8'h00;
    check_word(8'hFF, W, 1'b0, rx_word);
    check("rx_ff", 32'(rx_word), 32'h0000_00FF);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_word(8'h00, W, 1'b1, rx_word);
    check("rx_00", 32'(rx_word), 32'h0000_0000);
    check_idle_done();

    // Stall: 3C offered mid-word must wait until the current word ends.
    offer(8'hC3);
    fork
      check_word(8'hC3, W, 1'b0, rx_word);
      begin
        repeat (3) @(negedge clk);
        par_in   = 8'h3C;
        in_valid = 1'b1;
      end
    join
    check("rx_c3", 32'(rx_word), 32'h0000_00C3);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_word(8'h3C, W, 1'b1, rx_word);
    check("rx_3c", 32'(rx_word), 32'h0000_003C);
    check_idle_done();

    // Reset mid-frame after 3 bits of F0: word aborted, no done.
    offer(8'hF0);
    check_word(8'hF0, 3, 1'b0, rx_word);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_ser",   32'(serial_out), 32'd0);
    check("abort_frame", 32'(frame), 32'd0);
    check("abort_busy",  32'(busy), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd1);
    check("abort_done",  32'(done), 32'd0);
    @(negedge clk);
    check("abort_done2", 32'(done), 32'd0);
    offer(8'h81);
    check_word(8'h81, W, 1'b0, rx_word);
    check("rx_81", 32'(rx_word), 32'h0000_0081);
    check_idle_done();

    // Loopback word 5A.
    offer(8'h5A);
    check_word(8'h5A, W, 1'b0, rx_word);
    check("rx_5a", 32'(rx_word), 32'h0000_005A);
    check_idle_done();

`ifdef PISO_PARITY_EN
    // Parity bit: 07 has odd weight -> 1, 03 has even weight -> 0.
    offer(8'h07);
    check_word(8'h07, W, 1'b0, rx_word);
    check("par_07", 32'(serial_out), 32'd1);
    check_idle_done();
    offer(8'h03);
    check_word(8'h03, W, 1'b0, rx_word);
    check("par_03", 32'(serial_out), 32'd0);
    check_idle_done();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
